// File: rtl/speed_ctrl.sv
// Three-button speed selector: each raw button is synchronized and debounced,
// and its rising edge drives a LOW/MID/HIGH/PAUSE mode FSM.

module speed_ctrl_db #(
    parameter int DC = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_press
);
    localparam int CW = $clog2(DC + 1);

    logic          r_s1, r_s2, r_db, r_db_q;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_db   <= 1'b0;
            r_db_q <= 1'b0;
            r_cnt  <= '0;
        end else begin
            r_s1   <= i_btn;
            r_s2   <= r_s1;
            r_db_q <= r_db;
            // Any sample agreeing with db restarts the window, so only a
            // run of DC consecutive disagreeing samples flips db.
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DC - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    assign o_press = r_db & ~r_db_q;
endmodule

module speed_ctrl #(
    parameter logic [27:0] CLK_FREQ    = 28'd100_000_000,
    parameter int          DEBOUNCE_MS = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_pause,
    output logic [1:0] status,
    output logic       changed
);
    localparam int DEBOUNCE_CYCLES = int'(CLK_FREQ) / 1000 * DEBOUNCE_MS;
    localparam int NUM_BTN = 3;

    localparam logic [1:0] S_LOW   = 2'd0;
    localparam logic [1:0] S_MID   = 2'd1;
    localparam logic [1:0] S_HIGH  = 2'd2;
    localparam logic [1:0] S_PAUSE = 2'd3;

    logic [NUM_BTN-1:0] w_btn, w_press;
    logic [1:0]         r_state, r_saved, w_nxt, w_nxt_saved;
    logic               r_changed;
    logic               w_up, w_down, w_pause;

    assign w_btn = {btn_pause, btn_down, btn_up};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            speed_ctrl_db #(.DC(DEBOUNCE_CYCLES)) u_db (
                .clk    (clk),
                .rst_n  (rst_n),
                .i_btn  (w_btn[g]),
                .o_press(w_press[g])
            );
        end
    endgenerate

    assign w_up    = w_press[0];
    assign w_down  = w_press[1];
    assign w_pause = w_press[2];

    always_comb begin
        w_nxt       = r_state;
        w_nxt_saved = r_saved;
        if (w_pause) begin
            if (r_state == S_PAUSE) begin
                w_nxt = r_saved;
            end else begin
                w_nxt_saved = r_state;
                w_nxt       = S_PAUSE;
            end
        end else if ((w_up ^ w_down) && r_state != S_PAUSE) begin
            // Opposing requests in the same cycle cancel each other.
            if (w_up) begin
                if (r_state == S_LOW)      w_nxt = S_MID;
                else if (r_state == S_MID) w_nxt = S_HIGH;
            end else begin
                if (r_state == S_HIGH)     w_nxt = S_MID;
                else if (r_state == S_MID) w_nxt = S_LOW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= S_LOW;
            r_saved   <= S_LOW;
            r_changed <= 1'b0;
        end else begin
            r_state   <= w_nxt;
            r_saved   <= w_nxt_saved;
            r_changed <= (w_nxt != r_state);
        end
    end

    assign status  = r_state;
    assign changed = r_changed;
endmodule
